// File: rtl/alu_writeback_pkg.sv
// Shared opcode map, destination codes, state encoding and opcode classifier for alu_writeback.
// Constants are int unsigned so callers compare against a zero-extended opcode of any width.
package alu_writeback_pkg;

  localparam int unsigned OP_AND  = 32'h00;
  localparam int unsigned OP_OR   = 32'h01;
  localparam int unsigned OP_XOR  = 32'h02;
  localparam int unsigned OP_ANDN = 32'h03;
  localparam int unsigned OP_ORN  = 32'h04;
  localparam int unsigned OP_XORN = 32'h05;
  localparam int unsigned OP_NOT  = 32'h06;
  localparam int unsigned OP_ADD  = 32'h07;
  localparam int unsigned OP_SUB  = 32'h08;
  localparam int unsigned OP_MUL  = 32'h09;
  localparam int unsigned OP_DIV  = 32'h0A;
  localparam int unsigned OP_MOD  = 32'h0B;
  localparam int unsigned OP_SHL  = 32'h0C;
  localparam int unsigned OP_SHR  = 32'h0D;
  localparam int unsigned OP_ROL  = 32'h0E;
  localparam int unsigned OP_ROR  = 32'h0F;
  localparam int unsigned OP_MOVE = 32'h10;
  localparam int unsigned OP_LDN  = 32'h11;
  localparam int unsigned OP_S    = 32'h1B;
  localparam int unsigned OP_R    = 32'h1C;
  localparam int unsigned OP_ST   = 32'h1D;
  localparam int unsigned OP_STN  = 32'h1E;
  localparam int unsigned OP_LD   = 32'h1F;
  localparam int unsigned OP_LDC  = 32'h20;

  localparam int unsigned DST_RF   = 0;
  localparam int unsigned DST_BIT  = 1;
  localparam int unsigned DST_WORD = 2;
  localparam int unsigned DST_IMM  = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_PULSE = 2'd1,
    ST_WORD_REQ = 2'd2
  } wb_state_e;

  typedef enum logic [1:0] {
    OPC_ACC   = 2'd0,
    OPC_STORE = 2'd1,
    OPC_NONE  = 2'd2
  } op_class_e;

  function automatic op_class_e classify(input int unsigned op);
    if (op <= OP_LDN || op == OP_LD || op == OP_LDC)
      return OPC_ACC;
    else if (op >= OP_S && op <= OP_STN)
      return OPC_STORE;
    else
      return OPC_NONE;
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// Result-in / store-out bundle of alu_writeback; master is the ALU + store side, slave is the block.
// Handshake is valid/ready on the result side and req/ack on the word-memory side.
interface alu_writeback_if #(
  parameter int WIDTH   = 8,
  parameter int IWIDTH  = 8,
  parameter int AWIDTH  = 8,
  parameter int SOURCES = 4
);
  localparam int SEL_W = $clog2(SOURCES);

  logic              in_valid;
  logic              in_ready;
  logic [IWIDTH-1:0] op_code;
  logic [SEL_W-1:0]  dest_choice;
  logic [AWIDTH-1:0] dest_addr;
  logic [WIDTH-1:0]  alu_out;
  logic              alu_c_out;
  logic              alu_b_out;
  logic [WIDTH-1:0]  acc;
  logic              c_flag;
  logic              b_flag;
  logic              rf_we;
  logic [AWIDTH-1:0] rf_addr;
  logic [WIDTH-1:0]  rf_wdata;
  logic              bit_mem_we;
  logic [AWIDTH-1:0] bit_mem_addr;
  logic              bit_mem_wdata;
  logic              word_mem_req;
  logic [AWIDTH-1:0] word_mem_addr;
  logic [WIDTH-1:0]  word_mem_wdata;
  logic              word_mem_ack;
  logic              err;
  logic              err_clr;

  modport master (
    output in_valid, op_code, dest_choice, dest_addr, alu_out, alu_c_out, alu_b_out,
           word_mem_ack, err_clr,
    input  in_ready, acc, c_flag, b_flag, rf_we, rf_addr, rf_wdata,
           bit_mem_we, bit_mem_addr, bit_mem_wdata,
           word_mem_req, word_mem_addr, word_mem_wdata, err
  );

  modport slave (
    input  in_valid, op_code, dest_choice, dest_addr, alu_out, alu_c_out, alu_b_out,
           word_mem_ack, err_clr,
    output in_ready, acc, c_flag, b_flag, rf_we, rf_addr, rf_wdata,
           bit_mem_we, bit_mem_addr, bit_mem_wdata,
           word_mem_req, word_mem_addr, word_mem_wdata, err
  );

endinterface

// File: rtl/alu_writeback_timeout_cnt.sv
// Counts word-request cycles: load marks the first req cycle, expire flags the TIMEOUT-th cycle.
// Latency 0 from count to expire; no backpressure, saturates at TIMEOUT.
module wb_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= CW'(1);
    else if (en && !expire)
      cnt <= cnt + CW'(1);
  end

  assign expire = (cnt == CW'(TIMEOUT));

endmodule

// File: rtl/alu_writeback.sv
// Retires ALU results into ACC/C/B (1 per cycle) or issues rf/bit strobes (2-cycle) and word writes (req/ack, timeout).
// in_ready is registered and high only in IDLE; all strobes and req are registered.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int IWIDTH  = 8,
  parameter int AWIDTH  = 8,
  parameter int SOURCES = 4,
  parameter int TIMEOUT = 15
) (
  input logic         clk,
  input logic         rst_n,
  alu_writeback_if.slave bus
);
  localparam int SEL_W = $clog2(SOURCES);

  wb_state_e         state;
  logic [WIDTH-1:0]  acc_q;
  logic              c_q;
  logic              b_q;
  logic              err_q;
  logic              ready_q;
  logic              rf_we_q;
  logic              bit_we_q;
  logic              req_q;
  logic [AWIDTH-1:0] addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic              bit_wdata_q;

  logic [IWIDTH-1:0] op;
  logic [SEL_W-1:0]  dest;
  op_class_e         op_cls;
  logic              accept;
  logic              store_acc;
  logic              dest_rf;
  logic              dest_bit;
  logic              dest_word;
  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_expire;
  logic              err_set;

  assign op        = bus.op_code;
  assign dest      = bus.dest_choice;
  assign op_cls    = classify(32'(op));
  // ready_q is only ever high in IDLE, so it doubles as the state qualifier here.
  assign accept    = bus.in_valid & ready_q;
  assign store_acc = accept & (op_cls == OPC_STORE);
  assign dest_rf   = (32'(dest) == DST_RF);
  assign dest_bit  = (32'(dest) == DST_BIT);
  assign dest_word = (32'(dest) == DST_WORD);

  assign cnt_load  = store_acc & dest_word;
  assign cnt_en    = (state == ST_WORD_REQ);
  // Any select outside rf/bit/word (the immediate path) cannot be a store target.
  assign err_set   = (store_acc & ~dest_rf & ~dest_bit & ~dest_word)
                   | ((state == ST_WORD_REQ) & ~bus.word_mem_ack & cnt_expire);

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cnt_load),
    .en     (cnt_en),
    .expire (cnt_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      acc_q       <= '0;
      c_q         <= 1'b0;
      b_q         <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      rf_we_q     <= 1'b0;
      bit_we_q    <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bit_wdata_q <= 1'b0;
    end else begin
      err_q <= err_set | (err_q & ~bus.err_clr);
      case (state)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept && op_cls == OPC_ACC) begin
            acc_q <= bus.alu_out;
            if (32'(op) == OP_ADD) c_q <= bus.alu_c_out;
            if (32'(op) == OP_SUB) b_q <= bus.alu_b_out;
          end
          if (store_acc && (dest_rf || dest_bit || dest_word)) begin
            addr_q      <= bus.dest_addr;
            wdata_q     <= bus.alu_out;
            bit_wdata_q <= bus.alu_out[0];
            ready_q     <= 1'b0;
            if (dest_word) begin
              req_q <= 1'b1;
              state <= ST_WORD_REQ;
            end else begin
              rf_we_q  <= dest_rf;
              bit_we_q <= dest_bit;
              state    <= ST_WR_PULSE;
            end
          end
        end
        ST_WR_PULSE: begin
          rf_we_q  <= 1'b0;
          bit_we_q <= 1'b0;
          ready_q  <= 1'b1;
          state    <= ST_IDLE;
        end
        ST_WORD_REQ: begin
          // Ack is checked before expiry, so an ack on the last allowed cycle still succeeds.
          if (bus.word_mem_ack || cnt_expire) begin
            req_q   <= 1'b0;
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          rf_we_q  <= 1'b0;
          bit_we_q <= 1'b0;
          req_q    <= 1'b0;
          ready_q  <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready       = ready_q;
  assign bus.acc            = acc_q;
  assign bus.c_flag         = c_q;
  assign bus.b_flag         = b_q;
  assign bus.err            = err_q;
  assign bus.rf_we          = rf_we_q;
  assign bus.rf_addr        = addr_q;
  assign bus.rf_wdata       = wdata_q;
  assign bus.bit_mem_we     = bit_we_q;
  assign bus.bit_mem_addr   = addr_q;
  assign bus.bit_mem_wdata  = bit_wdata_q;
  assign bus.word_mem_req   = req_q;
  assign bus.word_mem_addr  = addr_q;
  assign bus.word_mem_wdata = wdata_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed plus randomized checks of alu_writeback against a transaction-level model of ACC/C/B/err.
module tb_alu_writeback;
  localparam int WIDTH   = 8;
  localparam int IWIDTH  = 8;
  localparam int AWIDTH  = 8;
  localparam int SOURCES = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] exp_acc = 8'h00;
  logic       exp_c   = 1'b0;
  logic       exp_b   = 1'b0;
  logic       exp_err = 1'b0;

  alu_writeback_if #(.WIDTH(WIDTH), .IWIDTH(IWIDTH), .AWIDTH(AWIDTH), .SOURCES(SOURCES)) bus ();

  alu_writeback #(
    .WIDTH(WIDTH), .IWIDTH(IWIDTH), .AWIDTH(AWIDTH), .SOURCES(SOURCES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_acc_op(input logic [7:0] op);
    return (op <= 8'h11) || (op == 8'h1F) || (op == 8'h20);
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, ".acc"}, bus.acc, exp_acc);
    chk({tag, ".c"},   bus.c_flag, exp_c);
    chk({tag, ".b"},   bus.b_flag, exp_b);
    chk({tag, ".err"}, bus.err, exp_err);
  endtask

  task automatic send(input logic [7:0] op, input logic [1:0] dst, input logic [7:0] addr,
                      input logic [7:0] data, input logic co, input logic bo);
    bus.in_valid    = 1'b1;
    bus.op_code     = op;
    bus.dest_choice = dst;
    bus.dest_addr   = addr;
    bus.alu_out     = data;
    bus.alu_c_out   = co;
    bus.alu_b_out   = bo;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Result with no store side effect: ACC-class or an unassigned opcode.
  task automatic do_acc(input string tag, input logic [7:0] op, input logic [7:0] data,
                        input logic co, input logic bo);
    send(op, 2'($urandom_range(0, 3)), 8'($urandom), data, co, bo);
    if (is_acc_op(op)) begin
      exp_acc = data;
      if (op == 8'h07) exp_c = co;
      if (op == 8'h08) exp_b = bo;
    end
    chk_model(tag);
    chk({tag, ".ready"}, bus.in_ready, 1'b1);
    chk({tag, ".strobes"}, {bus.rf_we, bus.bit_mem_we, bus.word_mem_req}, 3'b000);
  endtask

  task automatic do_pulse(input string tag, input logic [7:0] op, input logic dst_bit,
                          input logic [7:0] addr, input logic [7:0] data);
    send(op, {1'b0, dst_bit}, addr, data, 1'b1, 1'b1);
    chk({tag, ".we"}, {bus.rf_we, bus.bit_mem_we}, dst_bit ? 2'b01 : 2'b10);
    if (dst_bit) begin
      chk({tag, ".addr"},  bus.bit_mem_addr, addr);
      chk({tag, ".wdata"}, bus.bit_mem_wdata, data[0]);
    end else begin
      chk({tag, ".addr"},  bus.rf_addr, addr);
      chk({tag, ".wdata"}, bus.rf_wdata, data);
    end
    chk({tag, ".busy"}, bus.in_ready, 1'b0);
    chk_model(tag);
    tick();
    chk({tag, ".we_end"}, {bus.rf_we, bus.bit_mem_we}, 2'b00);
    chk({tag, ".ready_end"}, bus.in_ready, 1'b1);
  endtask

  // ack_at: req cycle (1-based) on which ack is driven; out of 1..TIMEOUT means never.
  task automatic do_word(input string tag, input logic [7:0] op, input logic [7:0] addr,
                         input logic [7:0] data, input int ack_at);
    int n = 0;
    int exp_n;
    send(op, 2'b10, addr, data, 1'b0, 1'b0);
    chk({tag, ".req"},   bus.word_mem_req, 1'b1);
    chk({tag, ".addr"},  bus.word_mem_addr, addr);
    chk({tag, ".wdata"}, bus.word_mem_wdata, data);
    while (bus.word_mem_req === 1'b1 && n < 3 * TIMEOUT) begin
      n++;
      bus.word_mem_ack = (n == ack_at);
      tick();
      bus.word_mem_ack = 1'b0;
    end
    if (ack_at >= 1 && ack_at <= TIMEOUT) exp_n = ack_at;
    else begin
      exp_n   = TIMEOUT;
      exp_err = 1'b1;
    end
    chk({tag, ".req_cycles"}, n, exp_n);
    chk({tag, ".ready_end"}, bus.in_ready, 1'b1);
    chk_model(tag);
  endtask

  task automatic do_imm(input string tag, input logic [7:0] op, input logic clr);
    bus.err_clr = clr;
    send(op, 2'b11, 8'($urandom), 8'($urandom), 1'b1, 1'b1);
    bus.err_clr = 1'b0;
    exp_err = 1'b1;
    chk({tag, ".strobes"}, {bus.rf_we, bus.bit_mem_we, bus.word_mem_req}, 3'b000);
    chk({tag, ".ready"}, bus.in_ready, 1'b1);
    chk_model(tag);
  endtask

  task automatic do_clr(input string tag);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    exp_err = 1'b0;
    chk_model(tag);
  endtask

  initial begin
    logic [7:0] op;
    int         pick;

    bus.in_valid = 1'b0; bus.op_code = '0; bus.dest_choice = '0; bus.dest_addr = '0;
    bus.alu_out = '0; bus.alu_c_out = 1'b0; bus.alu_b_out = 1'b0;
    bus.word_mem_ack = 1'b0; bus.err_clr = 1'b0;

    tick();
    tick();
    chk("reset.ready", bus.in_ready, 1'b0);
    chk("reset.strobes", {bus.rf_we, bus.bit_mem_we, bus.word_mem_req}, 3'b000);
    chk_model("reset");
    rst_n = 1'b1;
    tick();
    chk("post_reset.ready", bus.in_ready, 1'b1);

    do_acc("add", 8'h07, 8'h2A, 1'b1, 1'b0);
    do_acc("and", 8'h00, 8'h0F, 1'b0, 1'b1);
    do_acc("sub", 8'h08, 8'h10, 1'b0, 1'b1);
    do_acc("ldc", 8'h20, 8'hC3, 1'b0, 1'b0);
    do_acc("other", 8'h15, 8'h99, 1'b0, 1'b0);

    do_pulse("st_rf", 8'h1D, 1'b0, 8'h05, 8'h77);
    do_pulse("s_bit", 8'h1B, 1'b1, 8'h10, 8'hFF);
    do_pulse("r_bit", 8'h1C, 1'b1, 8'h10, 8'h00);

    do_word("word_ack3", 8'h1D, 8'h33, 8'hA5, 3);
    do_word("word_noack", 8'h1D, 8'h34, 8'h5A, 0);
    do_clr("clr1");
    do_word("word_ack_last", 8'h1E, 8'h35, 8'h3C, TIMEOUT);
    do_word("word_ack_first", 8'h1D, 8'h36, 8'hC3, 1);

    bus.word_mem_ack = 1'b1;
    tick();
    bus.word_mem_ack = 1'b0;
    chk("stray_ack.req", bus.word_mem_req, 1'b0);
    chk("stray_ack.ready", bus.in_ready, 1'b1);
    chk_model("stray_ack");

    do_imm("imm", 8'h1E, 1'b0);
    do_clr("clr2");
    do_imm("imm_set_wins", 8'h1D, 1'b1);
    do_clr("clr3");

    for (int i = 0; i < 80; i++) begin
      pick = $urandom_range(0, 9);
      if (pick <= 3) begin
        pick = $urandom_range(0, 19);
        op = (pick <= 17) ? 8'(pick) : ((pick == 18) ? 8'h1F : 8'h20);
        do_acc("rnd_acc", op, 8'($urandom), 1'($urandom), 1'($urandom));
      end else if (pick == 4) begin
        op = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8'h12, 8'h1A))
                                         : 8'($urandom_range(8'h21, 8'hFF));
        do_acc("rnd_other", op, 8'($urandom), 1'($urandom), 1'($urandom));
      end else if (pick == 5 || pick == 6) begin
        do_pulse("rnd_pulse", 8'($urandom_range(8'h1B, 8'h1E)), (pick == 6),
                 8'($urandom), 8'($urandom));
      end else if (pick == 7) begin
        do_word("rnd_word", 8'($urandom_range(8'h1B, 8'h1E)), 8'($urandom), 8'($urandom),
                $urandom_range(1, TIMEOUT + 2));
      end else if (pick == 8) begin
        do_imm("rnd_imm", 8'($urandom_range(8'h1B, 8'h1E)), 1'($urandom));
      end else begin
        do_clr("rnd_clr");
      end
    end

    do_acc("pre_rst_add", 8'h07, 8'h5D, 1'b1, 1'b0);
    do_acc("pre_rst_sub", 8'h08, 8'h6E, 1'b0, 1'b1);
    do_imm("pre_rst_err", 8'h1D, 1'b0);
    send(8'h1D, 2'b10, 8'h44, 8'h88, 1'b0, 1'b0);
    tick();
    chk("mid_req.req", bus.word_mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    exp_acc = 8'h00; exp_c = 1'b0; exp_b = 1'b0; exp_err = 1'b0;
    chk("mid_rst.req", bus.word_mem_req, 1'b0);
    chk("mid_rst.ready", bus.in_ready, 1'b0);
    chk_model("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_release.ready", bus.in_ready, 1'b1);
    chk("mid_rst_release.req", bus.word_mem_req, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
Result-side counterpart of the ALU: accepts each ALU result with its opcode and destination select, and updates the accumulator and the carry/borrow flags. The C/B flags feed back to alu_c_in/alu_b_in, and the accumulator feeds the register-file/immediate path.
Store-class results are written to the register file, bit memory or word memory. Word memory uses a req/ack handshake with a timeout.
The block sits between the ALU and the data stores. It is the only writer of ACC, C and B.

Parameters:
WIDTH, 8, data width of ACC, results and word writes
IWIDTH, 8, opcode width
AWIDTH, 8, destination address width (rf, bit and word memory)
SOURCES, 4, number of destination-select codes (select width = clog2(SOURCES))
TIMEOUT, 15, maximum cycles to wait for word_mem_ack before abort

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  result valid
in_ready  out  1  block can accept a result
op_code  in  IWIDTH  opcode of the result
dest_choice  in  clog2(SOURCES)  destination: 00 rf, 01 bit mem, 10 word mem, 11 illegal (immediate)
dest_addr  in  AWIDTH  destination address
alu_out  in  WIDTH  ALU result
alu_c_out  in  1  ALU carry out
alu_b_out  in  1  ALU borrow out
acc  out  WIDTH  accumulator
c_flag  out  1  carry flag (to alu_c_in)
b_flag  out  1  borrow flag (to alu_b_in)
rf_we  out  1  register-file write strobe
rf_addr  out  AWIDTH  register-file address
rf_wdata  out  WIDTH  register-file data
bit_mem_we  out  1  bit-memory write strobe
bit_mem_addr  out  AWIDTH  bit-memory address
bit_mem_wdata  out  1  bit-memory data
word_mem_req  out  1  word-memory write request
word_mem_addr  out  AWIDTH  word-memory address
word_mem_wdata  out  WIDTH  word-memory data
word_mem_ack  in  1  word-memory write acknowledge
err  out  1  sticky error
err_clr  in  1  clears err

Behaviour:
- Reset: one clock clk, asynchronous active-low reset rst_n. While rst_n=0, all outputs are 0, state is IDLE, and ACC, C, B and the timeout counter are 0. An in-flight word request drops immediately, with no completion.
- States: IDLE, WR_PULSE, WORD_REQ.
- in_ready=1 only in IDLE. A transfer occurs on the rising edge with in_valid&in_ready. The latched op/dest/addr/data stay stable until return to IDLE.
- Opcode classes:
  - ACC class (0x00-0x11, 0x1F, 0x20): ACC<=alu_out on the accept edge; stay in IDLE. Throughput 1 per cycle, latency 1.
  - 0x07 also sets C<=alu_c_out. 0x08 also sets B<=alu_b_out. No other opcode touches C or B.
  - Store class (0x1B-0x1E): ACC unchanged.
    - dest 00: go to WR_PULSE; rf_we=1 for exactly one cycle with rf_addr/rf_wdata=latched values; then IDLE. Occupancy 2 cycles.
    - dest 01: same as dest 00, but bit_mem_we, bit_mem_wdata=alu_out[0].
    - dest 10: go to WORD_REQ; word_mem_req=1 with addr/wdata held. On the edge where ack=1, return to IDLE and deassert req. Ack in the first req cycle is legal (2-cycle occupancy).
    - dest 11: no write; err<=1; stay in IDLE.
  - Other opcodes: accepted, no effect.
- Timeout: the counter runs in WORD_REQ. If ack has not been seen after TIMEOUT req cycles: drop req, set err<=1, return to IDLE. Ack on the final allowed cycle counts as success.
- err: sticky. err_clr=1 clears it on the next edge. A set and a clear on the same edge: set wins.
- ack outside WORD_REQ is ignored.
- Strobes and req are registered outputs; no combinational path from in_* to them.

Decomposition:
- Shared package/include: opcode constants (OP_AND..OP_LDN, OP_S, OP_R, OP_ST, OP_STN, OP_LD), destination codes (DST_RF, DST_BIT, DST_WORD, DST_IMM), state encoding.
- One sub-module: wb_timeout_cnt (load/enable/expire, TIMEOUT parameter).

Test Plan:
- Reset mid-WORD_REQ: drive store dest 10, withhold ack, pulse rst_n low -> word_mem_req=0 immediately; acc, c_flag, b_flag, err all 0.
- ADD chain: op 0x07, alu_out=0x2A, c_out=1 -> next cycle acc=0x2A, c_flag=1; then op 0x00, alu_out=0x0F -> acc=0x0F, c_flag still 1. Back-to-back accepts, in_ready stays 1.
- ST to rf: op 0x1D, dest 00, addr 0x05, alu_out=0x77 -> one rf_we pulse with rf_addr=0x05, rf_wdata=0x77; in_ready low for 1 cycle; acc unchanged.
- S to bit mem: op 0x1B, dest 01, addr 0x10, alu_out=0xFF -> one bit_mem_we pulse, bit_mem_wdata=1. R (alu_out=0x00) -> bit_mem_wdata=0.
- Word write with ack after 3 cycles -> req high exactly 3 cycles, then IDLE, err=0. Same write with no ack -> req high for 15 cycles, then err=1. err_clr -> err=0.
- Store with dest 11 -> no strobes, err=1, in_ready stays 1.
